jgn2: RTL and testbench

JGN2 -- requirements
Module: jgn2

---
 rtl/jgn2.sv | 63 ++++++
 tb/tb_jgn2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jgn2.sv
// One-step CORDIC micro-rotation (circular or linear) with a single registered output stage.
// The shifted cross terms are added or subtracted and wrap modulo 2^16.
module jgn2 (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               c2,
   input  logic               c1,
   input  logic               c0,
   input  logic signed [15:0] X,
   input  logic signed [15:0] Y,
   input  logic        [3:0]  j,
   output logic signed [15:0] Xnew,
   output logic signed [15:0] Ynew,
   output logic               out_valid
);

   localparam int DATA_W = 16;

   logic signed [DATA_W-1:0] w_xs;
   logic signed [DATA_W-1:0] w_ys;
   logic signed [DATA_W-1:0] w_xnext;
   logic signed [DATA_W-1:0] w_ynext;

   logic signed [DATA_W-1:0] r_xnew_p0;
   logic signed [DATA_W-1:0] r_ynew_p0;
   logic                     r_vld_p0;

   assign w_xs = X >>> j;
   assign w_ys = Y >>> j;

   // d = +1 when c0 is set; linear mode leaves X untouched
   always_comb begin
      w_xnext = X;
      w_ynext = Y;
      if (c1) begin
         if (c2) begin
            w_xnext = c0 ? (X - w_ys) : (X + w_ys);
         end
         w_ynext = c0 ? (Y + w_xs) : (Y - w_xs);
      end
   end

   // stage p0: output register, loaded only on a valid input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xnew_p0 <= '0;
         r_ynew_p0 <= '0;
         r_vld_p0  <= 1'b0;
      end else begin
         r_vld_p0 <= in_valid;
         if (in_valid) begin
            r_xnew_p0 <= w_xnext;
            r_ynew_p0 <= w_ynext;
         end
      end
   end

   assign Xnew      = r_xnew_p0;
   assign Ynew      = r_ynew_p0;
   assign out_valid = r_vld_p0;

endmodule

// File: tb/tb_jgn2.sv
// Scoreboard bench for jgn2: expected results are queued when driven and
// matched against Xnew/Ynew on every out_valid.
module tb_jgn2;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               c2;
   logic               c1;
   logic               c0;
   logic signed [15:0] X;
   logic signed [15:0] Y;
   logic        [3:0]  j;
   logic signed [15:0] Xnew;
   logic signed [15:0] Ynew;
   logic               out_valid;

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
   } exp_t;

   exp_t               sb[$];
   int                 n_vec;
   int                 n_fail;
   logic signed [15:0] last_x;
   logic signed [15:0] last_y;

   jgn2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .c2        (c2),
      .c1        (c1),
      .c0        (c0),
      .X         (X),
      .Y         (Y),
      .j         (j),
      .Xnew      (Xnew),
      .Ynew      (Ynew),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input bit m2, input bit m1, input bit m0,
                                  input logic signed [15:0] xi,
                                  input logic signed [15:0] yi,
                                  input int jj);
      exp_t e;
      int   x;
      int   y;
      int   xs;
      int   ys;
      int   d;
      int   xn;
      int   yn;
      x  = xi;
      y  = yi;
      xs = x >>> jj;
      ys = y >>> jj;
      d  = m0 ? 1 : -1;
      xn = x;
      yn = y;
      if (m1) begin
         if (m2) xn = x - d * ys;
         yn = y + d * xs;
      end
      e.x = xn[15:0];
      e.y = yn[15:0];
      return e;
   endfunction

   task automatic op(input bit m2, input bit m1, input bit m0,
                     input logic signed [15:0] xi, input logic signed [15:0] yi,
                     input logic [3:0] ji,
                     input logic signed [15:0] ex, input logic signed [15:0] ey);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      c2 = m2;
      c1 = m1;
      c0 = m0;
      X  = xi;
      Y  = yi;
      j  = ji;
      e.x = ex;
      e.y = ey;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         X = 16'sh5A5A;
         Y = -16'sh1234;
      end
   endtask

   // Every edge: a valid output must match the queue head; otherwise outputs hold.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         chk("rst_vld", {31'd0, out_valid}, 0);
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_depth_on_vld", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("Xnew", Xnew, e.x);
            chk("Ynew", Ynew, e.y);
            last_x = e.x;
            last_y = e.y;
         end
      end else begin
         chk("sb_pending", sb.size(), 0);
         chk("hold_X", Xnew, last_x);
         chk("hold_Y", Ynew, last_y);
      end
   end

   initial begin
      exp_t e;
      logic [3:0] rj;
      logic signed [15:0] rx;
      logic signed [15:0] ry;
      bit r2;
      bit r1;
      bit r0;
      n_vec    = 0;
      n_fail   = 0;
      last_x   = '0;
      last_y   = '0;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      c2 = 1'b1; c1 = 1'b1; c0 = 1'b1;
      X  = 16'sd2048; Y = 16'sd4096; j = 4'd9;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_X", Xnew, 0);
      chk("rst_Y", Ynew, 0);
      chk("rst_vld_hold", {31'd0, out_valid}, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      idle(2);

      op(1, 1, 1, 16'sd2048, 16'sd4096, 4'd9, 16'sd2040, 16'sd4100);
      op(1, 1, 0, 16'sd2048, 16'sd4096, 4'd9, 16'sd2056, 16'sd4092);
      op(0, 1, 1, 16'sd2048, 16'sd4096, 4'd9, 16'sd2048, 16'sd4100);
      op(0, 1, 0, 16'sd2048, 16'sd4096, 4'd9, 16'sd2048, 16'sd4092);
      op(0, 0, 1, 16'sd2048, 16'sd4096, 4'd9, 16'sd2048, 16'sd4096);
      op(1, 0, 0, -16'sd5, 16'sd7, 4'd3, -16'sd5, 16'sd7);
      op(1, 1, 1, -16'sd32768, 16'sd32767, 4'd0, 16'sd1, -16'sd1);
      op(1, 1, 1, -16'sd1, -16'sd1, 4'd15, 16'sd0, -16'sd2);
      op(1, 1, 1, 16'sd100, 16'sd200, 4'd15, 16'sd100, 16'sd200);
      op(1, 1, 0, 16'sd1000, -16'sd3000, 4'd2, 16'sd250, -16'sd3250);
      idle(3);

      for (int i = 0; i < 60; i++) begin
         r2 = 1'($urandom);
         r1 = ($urandom_range(0, 3) != 0);
         r0 = 1'($urandom);
         rx = 16'($urandom);
         ry = 16'($urandom);
         rj = 4'($urandom);
         e  = model(r2, r1, r0, rx, ry, int'(rj));
         op(r2, r1, r0, rx, ry, rj, e.x, e.y);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end

      // Reset arrives between edges while a new operation is presented.
      op(1, 1, 1, 16'sd2048, 16'sd4096, 4'd9, 16'sd2040, 16'sd4100);
      @(negedge clk);
      in_valid = 1'b1;
      X = 16'sd1234;
      Y = -16'sd4321;
      j = 4'd1;
      #2;
      rst_n  = 1'b0;
      last_x = '0;
      last_y = '0;
      #1;
      chk("async_rst_X", Xnew, 0);
      chk("async_rst_Y", Ynew, 0);
      chk("async_rst_vld", {31'd0, out_valid}, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      idle(4);

      e = model(1, 1, 0, -16'sd20000, 16'sd30000, 4);
      op(1, 1, 0, -16'sd20000, 16'sd30000, 4'd4, e.x, e.y);
      idle(3);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
